// File: rtl/xilinx_lutram_sdp_clr.sv
// Simple-dual-port LUT-RAM with one write and one read port on a single clock, selectable
// read-during-write behaviour, optional output register and a hardware clear sequencer.
module xilinx_lutram_sdp_clr #(
    parameter int               ABITS      = 7,
    parameter int               DBITS      = 4,
    parameter bit               OREG       = 1'b1,
    parameter bit               RDW_NEW    = 1'b0,
    parameter bit               INIT_CLEAR = 1'b1,
    parameter logic [DBITS-1:0] CLR_VAL    = '0
) (
    input  logic             WCLK,
    input  logic             RST_N,
    input  logic             clr_req,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] clr_ptr_q, clr_ptr_d;

    // Storage carries no reset so it maps onto plain LUT-RAM cells.
    logic [DBITS-1:0] mem_q [2**ABITS];

    logic             mem_we;
    logic [ABITS-1:0] mem_wa;
    logic [DBITS-1:0] mem_wd;
    logic             rdw_hit;
    logic             rd_accept;
    logic [DBITS-1:0] rd_word;

    assign busy = (state_q == S_CLEAR);

    always_ff @(posedge WCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= INIT_CLEAR ? S_CLEAR : S_READY;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_CLEAR: begin
                // The pointer wraps to zero on the last word, ready for the next request.
                clr_ptr_d = clr_ptr_q + ABITS'(1);
                if (clr_ptr_q == '1) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_READY;
        endcase
    end

    // The sequencer owns the write port while busy; user writes are dropped then.
    always_comb begin
        mem_we = RST_N & (busy | wr_en);
        mem_wa = busy ? clr_ptr_q : wr_addr;
        mem_wd = busy ? CLR_VAL : wr_data;
    end

    always_ff @(posedge WCLK) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign rd_accept = rd_en & ~busy;
    assign rdw_hit   = RDW_NEW & wr_en & ~busy & (wr_addr == rd_addr);
    assign rd_word   = rdw_hit ? wr_data : mem_q[rd_addr];

    generate
        if (OREG) begin : g_oreg
            logic [DBITS-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge WCLK or negedge RST_N) begin
                if (!RST_N) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        rd_data_q <= rd_word;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_comb
            assign rd_data  = rd_word;
            assign rd_valid = rd_accept;
        end
    endgenerate

endmodule
